// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg
// Shared definitions for the stream multiplexer: the mode encoding used on
// the `mode` input of stream_mux_rr and a helper for modulo-N pointer advance.
package stream_mux_pkg;

  typedef logic mode_t;

  localparam mode_t MODE_FIXED = 1'b0;
  localparam mode_t MODE_RR    = 1'b1;

  // Next rotating-pointer value after index idx, wrapping at n-1 back to 0.
  function automatic int wrap_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/stream_mux_rr_rr_arbiter.sv
// rr_arbiter
// Rotating priority encoder. Searches req starting at ptr, wrapping modulo
// NCH, and grants the first set bit.
//
// Ports:
//   req      in  NCH   request vector (one bit per channel)
//   ptr      in  SELW  search start index, expected in 0..NCH-1
//   gnt      out NCH   one-hot grant (all zero when no request)
//   gnt_idx  out SELW  index of the granted channel (0 when no grant)
//   gnt_any  out 1     a grant exists
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int SELW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic [NCH-1:0]  gnt,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_any
);

  int cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = 0;
    for (int k = 0; k < NCH; k++) begin
      // ptr never exceeds NCH-1, so one subtraction is enough to wrap.
      cand = int'(ptr) + k;
      if (cand >= NCH) cand = cand - NCH;
      if (!gnt_any && req[cand]) begin
        gnt[cand] = 1'b1;
        gnt_idx   = SELW'(cand);
        gnt_any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr
// N-channel stream multiplexer with a registered output stage and
// valid/ready handshakes. In fixed mode the channel named by `sel` is
// forwarded; in round-robin mode a rotating pointer picks among all valid
// channels, advancing past each channel it transfers from.
//
// Ports:
//   clk        in  1          clock, rising edge
//   rst        in  1          synchronous active-high reset
//   mode       in  1          MODE_FIXED (0) / MODE_RR (1)
//   sel        in  SELW       fixed-mode channel select (ignored in RR)
//   in_data    in  NCH*WIDTH  channel i at [i*WIDTH +: WIDTH]
//   in_valid   in  NCH        per-channel valid
//   in_ready   out NCH        per-channel ready, combinational, at most one set
//   out_data   out WIDTH      registered data
//   out_ch     out SELW       registered source channel of out_data
//   out_valid  out 1          registered valid
//   out_ready  in  1          consumer ready
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int WIDTH = 4,
  parameter int SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  mode_t                mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SELW-1:0]  out_ch_q,    out_ch_d;
  logic [SELW-1:0]  ptr_q,       ptr_d;

  logic [NCH-1:0]   rr_gnt;
  logic [SELW-1:0]  rr_idx;
  logic             rr_any;

  logic [NCH-1:0]   fix_gnt;
  logic [SELW-1:0]  fix_idx;
  logic             fix_any;

  logic [NCH-1:0]   gnt;
  logic [SELW-1:0]  gnt_idx;
  logic             gnt_any;
  logic             load;
  logic             xfer;

  rr_arbiter #(
    .NCH  (NCH),
    .SELW (SELW)
  ) u_arb (
    .req     (in_valid),
    .ptr     (ptr_q),
    .gnt     (rr_gnt),
    .gnt_idx (rr_idx),
    .gnt_any (rr_any)
  );

  // Fixed-mode grant. Matching sel against each legal index means an
  // out-of-range sel (non-power-of-2 NCH) simply finds no match.
  always_comb begin
    fix_gnt = '0;
    fix_idx = '0;
    fix_any = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (sel == SELW'(i) && in_valid[i]) begin
        fix_gnt[i] = 1'b1;
        fix_idx    = SELW'(i);
        fix_any    = 1'b1;
      end
    end
  end

  always_comb begin
    if (mode == MODE_RR) begin
      gnt     = rr_gnt;
      gnt_idx = rr_idx;
      gnt_any = rr_any;
    end else begin
      gnt     = fix_gnt;
      gnt_idx = fix_idx;
      gnt_any = fix_any;
    end
  end

  // The output register can take a new beat when empty or being drained.
  assign load = !out_valid_q || out_ready;
  assign xfer = load && gnt_any && !rst;

  // Gate with rst so no producer believes a beat was taken during reset.
  assign in_ready = (load && !rst) ? gnt : '0;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (load) begin
      out_valid_d = gnt_any;
      if (gnt_any) begin
        out_data_d = in_data[int'(gnt_idx)*WIDTH +: WIDTH];
        out_ch_d   = gnt_idx;
      end
    end
    if (xfer && mode == MODE_RR) begin
      ptr_d = SELW'(wrap_next(int'(gnt_idx), NCH));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
module tb_stream_mux_rr;
  import stream_mux_pkg::*;

  localparam int NCH   = 4;
  localparam int WIDTH = 4;
  localparam int SELW  = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  mode_t                mode;
  logic [SELW-1:0]      sel;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_ch;
  logic                 out_valid;
  logic                 out_ready;

  // Second instance with non-power-of-2 channel count.
  mode_t            mode3;
  logic [1:0]       sel3;
  logic [11:0]      in_data3;
  logic [2:0]       in_valid3;
  logic [2:0]       in_ready3;
  logic [3:0]       out_data3;
  logic [1:0]       out_ch3;
  logic             out_valid3;
  logic             out_ready3;

  int checks = 0;
  int errors = 0;
  bit model_on = 1'b0;

  always #5 clk = ~clk;

  stream_mux_rr #(.NCH(NCH), .WIDTH(WIDTH)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  stream_mux_rr #(.NCH(3), .WIDTH(4)) u_dut3 (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode3),
    .sel       (sel3),
    .in_data   (in_data3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .out_data  (out_data3),
    .out_ch    (out_ch3),
    .out_valid (out_valid3),
    .out_ready (out_ready3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the 4-channel instance: state after the last edge.
  logic             m_vld  = 1'b0;
  logic [WIDTH-1:0] m_data = '0;
  int               m_ch   = 0;
  int               m_ptr  = 0;

  always @(negedge clk) begin
    bit             ld;
    int             g;
    logic [NCH-1:0] exp_rdy;
    if (model_on) begin
      chk("m_out_valid", 32'(out_valid), 32'(m_vld));
      chk("m_out_data",  32'(out_data),  32'(m_data));
      chk("m_out_ch",    32'(out_ch),    32'(m_ch));
      ld = !m_vld || out_ready;
      g  = -1;
      if (mode == MODE_FIXED) begin
        if (int'(sel) < NCH && in_valid[sel]) g = int'(sel);
      end else begin
        for (int k = 0; k < NCH; k++)
          if (g < 0 && in_valid[(m_ptr + k) % NCH]) g = (m_ptr + k) % NCH;
      end
      exp_rdy = '0;
      if (!rst && ld && g >= 0) exp_rdy[g] = 1'b1;
      chk("m_in_ready", 32'(in_ready), 32'(exp_rdy));
      if (rst) begin
        m_vld = 1'b0; m_data = '0; m_ch = 0; m_ptr = 0;
      end else if (ld) begin
        if (g >= 0) begin
          m_vld  = 1'b1;
          m_data = in_data[g*WIDTH +: WIDTH];
          m_ch   = g;
          if (mode == MODE_RR) m_ptr = (g + 1) % NCH;
        end else begin
          m_vld = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; mode = MODE_FIXED; sel = '0; in_data = 16'h8765;
    in_valid = 4'hF; out_ready = 1'b1;
    mode3 = MODE_FIXED; sel3 = 2'd3; in_data3 = 12'h765; in_valid3 = 3'b000; out_ready3 = 1'b1;
    tick();
    model_on = 1'b1;
    tick();
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data",  32'(out_data), 0);
    chk("rst_out_ch",    32'(out_ch), 0);
    chk("rst_in_ready",  32'(in_ready), 0);

    // Fixed-mode stepping of sel.
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sel = SELW'(i);
      tick();
      chk("fix_out_data", 32'(out_data), 32'(5 + i));
      chk("fix_out_ch",   32'(out_ch), 32'(i));
      chk("fix_out_valid", 32'(out_valid), 1);
    end

    // Round-robin from reset release, all channels valid.
    rst = 1'b1; mode = MODE_RR;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rr_out_ch",   32'(out_ch), 32'(i % 4));
      chk("rr_out_data", 32'(out_data), 32'(5 + i % 4));
    end

    // ptr=1 with only ch0 and ch2 valid.
    rst = 1'b1; in_valid = 4'b0001;
    tick();
    rst = 1'b0;
    tick();
    in_valid = 4'b0101;
    #1;
    chk("sparse_rdy_a", 32'(in_ready), 32'h4);
    tick();
    chk("sparse_data_a", 32'(out_data), 7);
    #1;
    chk("sparse_rdy_b", 32'(in_ready), 32'h1);
    tick();
    chk("sparse_data_b", 32'(out_data), 5);
    tick();
    chk("sparse_data_c", 32'(out_data), 7);
    chk("sparse_ch_c",   32'(out_ch), 2);

    // Backpressure with out_ch=1 held for three cycles.
    rst = 1'b1; in_valid = 4'hF;
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("bp_setup_ch", 32'(out_ch), 1);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", 32'(in_ready), 0);
      tick();
      chk("bp_out_ch",    32'(out_ch), 1);
      chk("bp_out_data",  32'(out_data), 6);
      chk("bp_out_valid", 32'(out_valid), 1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rel_rdy", 32'(in_ready), 32'h4);
    tick();
    chk("bp_rel_ch", 32'(out_ch), 2);

    // Reset mid-stream.
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_data",  32'(out_data), 0);
    chk("mid_rst_ch",    32'(out_ch), 0);
    chk("mid_rst_rdy",   32'(in_ready), 0);
    rst = 1'b0;
    tick();
    chk("post_rst_ch",   32'(out_ch), 0);
    chk("post_rst_data", 32'(out_data), 5);

    // Fixed mode, selected channel not valid: output drains to empty.
    mode = MODE_FIXED; sel = 2'd2; in_valid = 4'b1011;
    #1;
    chk("novld_rdy", 32'(in_ready), 0);
    tick();
    chk("novld_valid", 32'(out_valid), 0);
    chk("novld_hold_data", 32'(out_data), 5);

    // NCH=3: out-of-range sel never grants; RR wraps 2 -> 0.
    in_valid3 = 3'b111;
    #1;
    chk("n3_oor_rdy", 32'(in_ready3), 0);
    tick();
    chk("n3_oor_valid", 32'(out_valid3), 0);
    mode3 = MODE_RR;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("n3_rr_ch",   32'(out_ch3), 32'(i % 3));
      chk("n3_rr_data", 32'(out_data3), 32'(5 + i % 3));
    end

    // Randomised traffic checked by the model every cycle.
    for (int n = 0; n < 2000; n++) begin
      rst       = ($urandom_range(63) == 0);
      mode      = mode_t'($urandom_range(1));
      if ($urandom_range(3) == 0) sel = SELW'($urandom_range(NCH - 1));
      in_valid  = NCH'($urandom);
      in_data   = (NCH*WIDTH)'($urandom);
      out_ready = ($urandom_range(3) != 0);
      tick();
    end

    model_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel stream multiplexer with a registered output and valid/ready handshakes. It generalises the team's 4:1 combinational mux: channel count and data width are parametrised, the output is registered, and a mode input selects either fixed selection (sel-driven, as in the 4:1 mux) or round-robin arbitration across all valid channels. It sits between multiple producer streams and a single consumer.

## Interface
- `NCH`, default 4: number of input channels (≥2).
- `WIDTH`, default 4: data width per channel.
- `SELW`, default `$clog2(NCH)`: width of the select and channel-ID fields.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `mode`  in  1  0 = fixed select (`MODE_FIXED`), 1 = round-robin (`MODE_RR`).
- `sel`  in  SELW  channel selected in fixed mode; ignored in RR mode.
- `in_data`  in  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- `in_valid`  in  NCH  per-channel valid.
- `in_ready`  out  NCH  per-channel ready (combinational).
- `out_data`  out  WIDTH  registered output data.
- `out_ch`  out  SELW  registered index of the channel that supplied `out_data`.
- `out_valid`  out  1  registered output valid.
- `out_ready`  in  1  consumer ready.

## Operation
- `load = !out_valid || out_ready`: the output register can accept a beat this cycle.
- Fixed mode:
  - Candidate is `sel`.
  - The grant is issued iff `sel < NCH` and `in_valid[sel]`.
  - An out-of-range `sel` never grants.
- RR mode:
  - Rotating pointer `ptr` (SELW bits, range 0..NCH-1).
  - Search starts at `ptr`, wraps modulo NCH, and grants the first channel with `in_valid` set.
- `in_ready[i] = load && grant[i]`. Exactly zero or one bit is set. `in_ready` depends combinationally on `in_valid`, `sel`, `mode` and `out_ready`.
- On a cycle with `load` set:
  - If a grant exists: `out_valid<=1`, `out_data<=in_data[g]`, `out_ch<=g`.
  - If no grant exists: `out_valid<=0`, and `out_data`/`out_ch` hold their values.
- On a cycle with `load` clear: all outputs and `ptr` hold (backpressure). All `in_ready` bits are 0.
- Pointer update: `ptr <= (g == NCH-1) ? 0 : g+1` only on an RR-mode transfer. In fixed mode `ptr` holds.
- A `mode` or `sel` change takes effect in the same cycle's grant. A beat already in the output register is unaffected.
- Each input beat is transferred exactly once. Beats are never duplicated or dropped.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_ch=0`, `ptr=0`. While `rst` is high, all `in_ready` bits are 0.
- Latency: 1 cycle. A beat accepted on edge k (`in_valid & in_ready` high) appears at `out_*` after edge k.
- Throughput: 1 beat/cycle while `out_ready` is held at 1.
- Output register with `out_valid=1, out_ready=1` and a grant present: the register is replaced in the same edge, with no bubble.
- Reset mid-stream: a pending output beat is discarded, and `ptr` returns to 0 on the next edge. After reset, the first RR grant goes to the lowest-index valid channel.
- For non-power-of-2 NCH, `ptr` wraps at NCH-1 to 0 and never takes the values NCH..2^SELW-1.

## Structure
- Shared package `stream_mux_pkg`: `MODE_FIXED`, `MODE_RR` constants, and a typedef for the mode bit.
- One sub-module, `rr_arbiter`:
  - Inputs: `NCH`-bit request vector and `ptr`.
  - Outputs: one-hot grant plus grant index, combinational, as a rotating priority encoder.
  - Top level: the fixed-mode override, the handshake logic and the output and pointer registers.

## Test plan
1. Fixed mode, NCH=4, WIDTH=4, `in_data` ch0..3 = 5,6,7,8, all valid, `out_ready=1`, `sel` stepping 0,1,2,3 one per cycle → `out_data` 5,6,7,8 and `out_ch` 0..3, each one cycle after its `sel`.
2. RR mode, same data, all valid, `out_ready=1` from reset release → `out_ch` 0,1,2,3,0,1 on consecutive cycles, with `out_data` 5,6,7,8,5,6.
3. RR mode with `ptr=1` and only ch0 and ch2 valid (held) → grant ch2 (`out_data=7`), then ch0 (5), then ch2; `in_ready[1]` and `in_ready[3]` stay 0.
4. Backpressure: `out_valid=1`, `out_ch=1`, `out_ready=0` for 3 cycles → outputs and `ptr` hold and all `in_ready` are 0. When `out_ready=1`, ch2 is the next beat.
5. Reset mid-stream: assert `rst` for 1 cycle while `out_valid=1` → `out_valid=0`, `out_data=0`, `out_ch=0`. With all channels valid afterwards, the first `out_ch` is 0.
6. Fixed mode, `sel=2` with `in_valid[2]=0`, NCH=3 variant with `sel=3` → no `in_ready` asserted, and `out_valid` drops to 0 after the current beat drains.
